// File: rtl/lbm_fixed_pkg.sv
// Shared Q-format definitions for the LBM fixed-point datapath (default Q8.56).
package lbm_fixed_pkg;

    localparam int FX_DATA_WIDTH = 64;
    localparam int FX_FRAC_BITS  = 56;

    typedef logic signed [FX_DATA_WIDTH-1:0] fx_t;

    localparam fx_t FX_ONE = {{(FX_DATA_WIDTH-FX_FRAC_BITS-1){1'b0}}, 1'b1, {FX_FRAC_BITS{1'b0}}};
    localparam fx_t FX_MAX = {1'b0, {(FX_DATA_WIDTH-1){1'b1}}};
    localparam fx_t FX_MIN = {1'b1, {(FX_DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fx_round_sat.sv
// Maps a full-width signed Q-format product back to W bits: optional
// round-half-up, arithmetic shift by F, overflow detect, optional clamp.
module fx_round_sat #(
    parameter int W = 64,
    parameter int F = 56
) (
    input  logic signed [2*W-1:0] prod,
    input  logic                  round_en,
    input  logic                  sat_en,
    output logic        [W-1:0]   res,
    output logic                  ovf
);

    localparam logic [2*W-1:0] HALF = {{(2*W-1){1'b0}}, 1'b1} << (F-1);
    localparam logic [W-1:0]   MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]   MINV = {1'b1, {(W-1){1'b0}}};

    logic [2*W-1:0]   pr;
    logic [2*W-F-1:0] r;
    logic [W-F:0]     hi;
    logic             unused_lsbs;

    // The largest product magnitude is 2^(2W-2), so the rounding add cannot wrap 2W bits.
    assign pr          = prod + (round_en ? HALF : '0);
    assign r           = pr[2*W-1:F];
    assign unused_lsbs = ^pr[F-1:0];

    // Result fits only if every bit from the sign position upward agrees.
    assign hi  = r[2*W-F-1:W-1];
    assign ovf = !((&hi) || !(|hi));
    assign res = (ovf && sat_en) ? (r[2*W-F-1] ? MINV : MAXV) : r[W-1:0];

endmodule

// File: rtl/fp_mult_pipe.sv
// Pipelined signed Q-format multiplier with rounding/saturation, overflow flag,
// sideband tag and valid/ready flow control.
module fp_mult_pipe
    import lbm_fixed_pkg::*;
#(
    parameter int DATA_WIDTH      = FX_DATA_WIDTH,
    parameter int FRACTIONAL_BITS = FX_FRAC_BITS,
    parameter int INTEGER_BITS    = DATA_WIDTH - FRACTIONAL_BITS,
    parameter int LATENCY         = 3,
    parameter int TAG_WIDTH       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic                  round_en,
    input  logic                  sat_en,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  ovf,
    output logic [TAG_WIDTH-1:0]  tag_out
);

    localparam int W = DATA_WIDTH;
    localparam int L = LATENCY;

    // Handshake: a beat moves on any edge where valid && ready. Stage k loads when
    // it is empty or its contents leave; ready never looks at the same side's valid.
    logic [L-1:0]           vld;
    logic [L-1:0]           adv;
    logic signed [W-1:0]    a_q, b_q;
    logic [L-2:0]           rnd_q, sat_q;
    logic [TAG_WIDTH-1:0]   tag_q [L-1];
    logic signed [2*W-1:0]  a_ext, b_ext, prod_c, fin_prod;
    logic [W-1:0]           res_c;
    logic                   ovf_c;

    // A stage is blocked only when it and every stage after it hold data and the output stalls.
    for (genvar k = 0; k < L; k++) begin : g_adv
        assign adv[k] = out_ready || !(&vld[L-1:k]);
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[L-1];

    assign a_ext  = {{W{a_q[W-1]}}, a_q};
    assign b_ext  = {{W{b_q[W-1]}}, b_q};
    assign prod_c = a_ext * b_ext;

    if (L > 2) begin : g_mid
        logic signed [2*W-1:0] prod_q [L-2];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < L-2; i++) prod_q[i] <= '0;
            end else begin
                if (adv[1] && vld[0]) prod_q[0] <= prod_c;
                for (int i = 1; i < L-2; i++) begin
                    if (adv[i+1] && vld[i]) prod_q[i] <= prod_q[i-1];
                end
            end
        end

        assign fin_prod = prod_q[L-3];
    end else begin : g_direct
        assign fin_prod = prod_c;
    end

    fx_round_sat #(
        .W (W),
        .F (DATA_WIDTH - INTEGER_BITS)
    ) u_round_sat (
        .prod     (fin_prod),
        .round_en (rnd_q[L-2]),
        .sat_en   (sat_q[L-2]),
        .res      (res_c),
        .ovf      (ovf_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rnd_q   <= '0;
            sat_q   <= '0;
            for (int i = 0; i < L-1; i++) tag_q[i] <= '0;
            dout    <= '0;
            ovf     <= 1'b0;
            tag_out <= '0;
        end else begin
            if (adv[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    a_q      <= din0;
                    b_q      <= din1;
                    rnd_q[0] <= round_en;
                    sat_q[0] <= sat_en;
                    tag_q[0] <= tag_in;
                end
            end
            for (int i = 1; i < L-1; i++) begin
                if (adv[i]) begin
                    vld[i] <= vld[i-1];
                    if (vld[i-1]) begin
                        rnd_q[i] <= rnd_q[i-1];
                        sat_q[i] <= sat_q[i-1];
                        tag_q[i] <= tag_q[i-1];
                    end
                end
            end
            if (adv[L-1]) begin
                vld[L-1] <= vld[L-2];
                if (vld[L-2]) begin
                    dout    <= res_c;
                    ovf     <= ovf_c;
                    tag_out <= tag_q[L-2];
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe: default Q8.56/LATENCY=3 instance plus a
// Q16.16/LATENCY=2 instance sharing clock and reset.
module tb_fp_mult_pipe;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required below 200000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- 64-bit instance ----------------
    logic        in_valid, in_ready, round_en, sat_en, out_valid, out_ready, ovf;
    logic [63:0] din0, din1, dout;
    logic [7:0]  tag_in, tag_out;

    fp_mult_pipe u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .round_en  (round_en),
        .sat_en    (sat_en),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .ovf       (ovf),
        .tag_out   (tag_out)
    );

    // ---------------- 32-bit instance ----------------
    logic        in_valid_s, in_ready_s, round_en_s, sat_en_s, out_valid_s, out_ready_s, ovf_s;
    logic [31:0] din0_s, din1_s, dout_s;
    logic [7:0]  tag_in_s, tag_out_s;

    fp_mult_pipe #(
        .DATA_WIDTH      (32),
        .FRACTIONAL_BITS (16),
        .LATENCY         (2),
        .TAG_WIDTH       (8)
    ) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_s),
        .in_ready  (in_ready_s),
        .din0      (din0_s),
        .din1      (din1_s),
        .round_en  (round_en_s),
        .sat_en    (sat_en_s),
        .tag_in    (tag_in_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready_s),
        .dout      (dout_s),
        .ovf       (ovf_s),
        .tag_out   (tag_out_s)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [71:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic op64(input string name, input logic [63:0] a, input logic [63:0] b,
                        input logic r, input logic s, input logic [7:0] t,
                        input logic [63:0] ed, input logic eo);
        int n;
        @(negedge clk); #1;
        din0 = a; din1 = b; round_en = r; sat_en = s; tag_in = t;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({name, "_in_ready"}, in_ready, 1);
        @(negedge clk); #1 in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, n, 3);
        chk({name, "_dout"}, dout, ed);
        chk({name, "_ovf"}, ovf, eo);
        chk({name, "_tag"}, tag_out, t);
    endtask

    task automatic op32(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic r, input logic s, input logic [7:0] t,
                        input logic [31:0] ed, input logic eo);
        int n;
        @(negedge clk); #1;
        din0_s = a; din1_s = b; round_en_s = r; sat_en_s = s; tag_in_s = t;
        in_valid_s = 1'b1; out_ready_s = 1'b1;
        #1 chk({name, "_in_ready"}, in_ready_s, 1);
        @(negedge clk); #1 in_valid_s = 1'b0;
        n = 1;
        while (!out_valid_s && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, n, 2);
        chk({name, "_dout"}, dout_s, ed);
        chk({name, "_ovf"}, ovf_s, eo);
        chk({name, "_tag"}, tag_out_s, t);
    endtask

    // Operand k is (k+1).0 * 1.5, so the expected result is 3*(k+1) in units of 2^55.
    task automatic run_stream(input bit full_rate, input string name);
        int          sent, got, t0, last, pb, cb;
        logic        held;
        logic [63:0] held_d;
        logic [7:0]  held_t;
        logic [71:0] e;
        sent = 0; got = 0; t0 = 0; last = 0; pb = 0; cb = 0;
        held = 1'b0; held_d = '0; held_t = '0;
        exp_q.delete();
        fork
            begin
                while (sent < 20 && pb < 400) begin
                    @(negedge clk); #1;
                    din0 = 64'(sent + 1) << 56; din1 = 64'h0180_0000_0000_0000;
                    round_en = 1'b0; sat_en = 1'b1; tag_in = 8'(sent); in_valid = 1'b1;
                    #1;
                    if (in_ready) begin
                        if (sent == 0) t0 = cyc + 1;
                        exp_q.push_back({8'(sent), 64'(3 * (sent + 1)) << 55});
                        sent++;
                    end else if (full_rate) begin
                        chk({name, "_in_ready"}, in_ready, 1);
                    end
                    pb++;
                end
                chk({name, "_sent"}, sent, 20);
                @(negedge clk); #1 in_valid = 1'b0;
            end
            begin
                while (got < 20 && cb < 400) begin
                    @(negedge clk);
                    out_ready = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
                    #2;
                    if (held) begin
                        chk({name, "_hold_valid"}, out_valid, 1);
                        chk({name, "_hold_dout"}, dout, held_d);
                        chk({name, "_hold_tag"}, tag_out, held_t);
                    end
                    if (out_valid && out_ready) begin
                        chk({name, "_q_nonempty"}, exp_q.size() != 0, 1);
                        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                        chk({name, "_dout"}, dout, e[63:0]);
                        chk({name, "_tag"}, tag_out, e[71:64]);
                        chk({name, "_ovf"}, ovf, 0);
                        if (full_rate) begin
                            if (got == 0) chk({name, "_first_latency"}, cyc - t0 + 1, 3);
                            else          chk({name, "_gap"}, cyc - last, 1);
                            last = cyc;
                        end
                        got++;
                    end
                    held   = out_valid && !out_ready;
                    held_d = dout;
                    held_t = tag_out;
                    cb++;
                end
                chk({name, "_count"}, got, 20);
            end
        join
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        in_valid = 0; din0 = '0; din1 = '0; round_en = 0; sat_en = 0; tag_in = '0; out_ready = 0;
        in_valid_s = 0; din0_s = '0; din1_s = '0; round_en_s = 0; sat_en_s = 0; tag_in_s = '0; out_ready_s = 0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_tag", tag_out, 0);
        chk("rst32_out_valid", out_valid_s, 0);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel32_in_ready", in_ready_s, 1);

        // basic product, rounding, overflow
        op64("mul_1p5_x2",   64'h0180_0000_0000_0000, 64'h0200_0000_0000_0000, 0, 1, 8'h05, 64'h0300_0000_0000_0000, 0);
        op64("lsb_half_trn", 64'h0000_0000_0000_0001, 64'h0080_0000_0000_0000, 0, 1, 8'h11, 64'h0000_0000_0000_0000, 0);
        op64("lsb_half_rnd", 64'h0000_0000_0000_0001, 64'h0080_0000_0000_0000, 1, 1, 8'h12, 64'h0000_0000_0000_0001, 0);
        op64("neg_half_trn", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0080_0000_0000_0000, 0, 1, 8'h13, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        op64("neg_half_rnd", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0080_0000_0000_0000, 1, 1, 8'h14, 64'h0000_0000_0000_0000, 0);
        op64("ovf_sat",      64'h6400_0000_0000_0000, 64'h0200_0000_0000_0000, 0, 1, 8'h21, 64'h7FFF_FFFF_FFFF_FFFF, 1);
        op64("ovf_wrap",     64'h6400_0000_0000_0000, 64'h0200_0000_0000_0000, 0, 0, 8'h22, 64'hC800_0000_0000_0000, 1);
        op64("min_sq_sat",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 1, 8'h23, 64'h7FFF_FFFF_FFFF_FFFF, 1);
        op64("neg_ovf_sat",  64'h9C00_0000_0000_0000, 64'h0200_0000_0000_0000, 0, 1, 8'h24, 64'h8000_0000_0000_0000, 1);
        op64("zero_op",      64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 1, 8'h25, 64'h0000_0000_0000_0000, 0);
        op64("neg_1p5_x2",   64'hFE80_0000_0000_0000, 64'h0200_0000_0000_0000, 0, 1, 8'h26, 64'hFD00_0000_0000_0000, 0);

        // streams with backpressure and at full rate
        run_stream(1'b0, "stream_rand");
        run_stream(1'b1, "stream_full");

        // fill with out_ready low, then reset mid-stream
        @(negedge clk); #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            din0 = 64'(i + 1) << 56; din1 = 64'h0100_0000_0000_0000;
            round_en = 0; sat_en = 1; tag_in = 8'(8'h40 + i); in_valid = 1'b1;
            #1 chk("fill_in_ready", in_ready, 1);
        end
        @(negedge clk); #2;
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        chk("full_dout", dout, 64'h0100_0000_0000_0000);
        chk("full_tag", tag_out, 8'h40);
        @(negedge clk); #2;
        chk("stall_in_ready", in_ready, 0);
        chk("stall_dout", dout, 64'h0100_0000_0000_0000);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_dout", dout, 0);
        chk("midrst_tag", tag_out, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("postrst_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            chk("postrst_no_output", out_valid, 0);
            @(negedge clk); #1;
        end

        // narrow instance, LATENCY=2
        op32("w32_1p5_x2",   32'h0001_8000, 32'h0002_0000, 0, 1, 8'h31, 32'h0003_0000, 0);
        op32("w32_ovf_sat",  32'h7FFF_0000, 32'h0002_0000, 0, 1, 8'h32, 32'h7FFF_FFFF, 1);
        op32("w32_ovf_wrap", 32'h7FFF_0000, 32'h0002_0000, 0, 0, 8'h33, 32'hFFFE_0000, 1);
        op32("w32_neg_trn",  32'hFFFF_FFFF, 32'h0000_8000, 0, 1, 8'h34, 32'hFFFF_FFFF, 0);
        op32("w32_neg_rnd",  32'hFFFF_FFFF, 32'h0000_8000, 1, 1, 8'h35, 32'h0000_0000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
Pipelined, parametrised signed fixed-point multiplier for the LBM collision and equilibrium datapath.
- Successor to the combinational Q-format multiplier. Default format is Q8.56 in 64 bits.
- Adds selectable rounding and saturation, an overflow flag and a pass-through tag.
- Adds a valid/ready handshake with backpressure, so it can sit between lattice-node streaming buffers and the collision accumulators at full clock rate.

Parameters:
DATA_WIDTH, 64, operand/result width in bits (signed two's complement).
FRACTIONAL_BITS, 56, fraction bits of operands and result; must be between 1 and DATA_WIDTH-2 inclusive.
INTEGER_BITS, DATA_WIDTH-FRACTIONAL_BITS, integer bits including sign (derived; not overridden).
LATENCY, 3, cycles from input handshake to output valid; legal range 2..6.
TAG_WIDTH, 8, width of sideband tag carried alongside each operation (lattice direction index).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operands and mode present.
in_ready  out  1  block accepts the operation this cycle.
din0  in  DATA_WIDTH  signed multiplicand.
din1  in  DATA_WIDTH  signed multiplier.
round_en  in  1  1 = round-half-up; 0 = truncate toward minus infinity (legacy behaviour).
sat_en  in  1  1 = clamp on overflow; 0 = wrap (keep low DATA_WIDTH bits).
tag_in  in  TAG_WIDTH  sideband, returned unchanged with the result.
out_valid  out  1  result present.
out_ready  in  1  downstream accepts the result.
dout  out  DATA_WIDTH  signed result.
ovf  out  1  overflow occurred for this result (qualified by out_valid).
tag_out  out  TAG_WIDTH  tag of this result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Every pipeline valid bit clears; out_valid=0.
  - dout=0, ovf=0, tag_out=0, and all data registers are 0.
  - in_ready=1 from the first cycle after release.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - round_en, sat_en and tag_in are sampled with the operands and travel with them.
- Pipeline:
  - LATENCY register stages, each with its own valid bit.
  - Stage 1 registers operands and modes.
  - Stages 2..LATENCY-1 hold the full 2*DATA_WIDTH signed product; with LATENCY=2, the product is formed combinationally between the stage-1 and final registers.
  - The final stage registers the rounded/saturated result, ovf and tag.
- Stall rule:
  - A stage advances when its successor is empty or advancing. The final stage advances when out_ready=1 or out_valid=0.
  - in_ready = stage 1 can advance.
  - Bubbles collapse: an empty stage accepts data even while the stages after it stall.
  - Sustained throughput is 1 op/cycle with out_ready held high. A stalled result holds dout/ovf/tag_out stable until accepted.
- Arithmetic (F = FRACTIONAL_BITS, W = DATA_WIDTH):
  - p = din0 * din1, computed full width (2W, signed).
  - If round_en: p' = p + 2^(F-1); else p' = p.
  - r = p' arithmetic-shifted right by F (2W-F bits kept).
  - Overflow when r > 2^(W-1)-1 or r < -2^(W-1), including overflow caused by the rounding add.
  - Result is r[W-1:0]; on overflow it is clamped to 2^(W-1)-1 or -2^(W-1) if sat_en, otherwise the wrapped bits are kept.
  - ovf is set on overflow regardless of sat_en.
- Boundary cases:
  - (-2^(W-1)) * (-2^(W-1)) overflows positive.
  - Any operand 0 gives 0 with ovf=0.
  - Simultaneous in and out handshakes on a full pipeline are allowed with no loss or duplication.
  - Reset asserted mid-operation discards all in-flight operations; no output is produced for them.
- in_ready never depends combinationally on in_valid. out_valid never depends combinationally on out_ready.

Decomposition:
- Package lbm_fixed_pkg holds:
  - default DATA_WIDTH/FRACTIONAL_BITS constants;
  - Q-format helpers: FX_ONE = 1<<F, FX_MAX, FX_MIN;
  - typedef fx_t (signed [DATA_WIDTH-1:0]).
- One combinational sub-module, fx_round_sat (parameters W, F), maps product, round_en and sat_en to result and ovf. It is reused by the future fixed-point adder and divider.

Test Plan:
1. Reset, then 0x0180_0000_0000_0000 (1.5) * 0x0200_0000_0000_0000 (2.0), round 0, sat 1, tag 0x05 -> after 3 cycles dout=0x0300_0000_0000_0000, ovf=0, tag_out=0x05.
2. Operands 0x0000_0000_0000_0001 * 0x0080_0000_0000_0000 (1 LSB * 0.5):
   - truncate -> dout=0;
   - round -> dout=1.
   Operands 0xFFFF_FFFF_FFFF_FFFF (-1 LSB) * 0.5:
   - truncate -> dout=0xFFFF_FFFF_FFFF_FFFF;
   - round -> dout=0.
3. 0x6400_0000_0000_0000 (100.0) * 2.0:
   - sat 1 -> dout=0x7FFF_FFFF_FFFF_FFFF, ovf=1;
   - sat 0 -> dout=0xC800_0000_0000_0000, ovf=1.
   0x8000_0000_0000_0000 squared with sat 1 -> 0x7FFF_FFFF_FFFF_FFFF, ovf=1.
4. Stream 20 ops with tags 0..19, random out_ready (~50%):
   - results in order, all tags present;
   - dout stable while out_valid && !out_ready;
   - 20 results total.
   Same stream with out_ready=1 -> one result per cycle, first at cycle 3.
5. Fill pipeline with 3 ops, hold out_ready=0 -> in_ready=0 after stages fill. Assert rst_n low mid-stream -> out_valid=0 immediately, no stale outputs after release.
6. Rebuild with DATA_WIDTH=32, FRACTIONAL_BITS=16, LATENCY=2:
   - 0x0001_8000 * 0x0002_0000 -> 0x0003_0000 after 2 cycles;
   - overflow clamps to 0x7FFF_FFFF.
